// File: rtl/tictac_pkg.sv
// Shared types and codes for the tic-tac-toe turn controller and its helpers.
package tictac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    P1_WAIT,
    P1_WRITE,
    P1_CHECK,
    P2_REQ,
    P2_WRITE,
    P2_CHECK,
    DONE
  } turn_state;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] P1    = 2'b11;
  localparam logic [1:0] P2    = 2'b10;

  localparam logic [1:0] NOWIN = 2'b00;
  localparam logic [1:0] TIE   = 2'b01;
  localparam logic [1:0] P1WIN = 2'b11;
  localparam logic [1:0] P2WIN = 2'b10;

  localparam logic [3:0]  BAD_ADDR  = 4'b1111;
  localparam int unsigned NUM_CELLS = 9;

endpackage

// File: rtl/game_turn_ctrl_cell_decode.sv
// Cell legality for one address plus lowest-index empty cell (BAD_ADDR when full).
module cell_decode
  import tictac_pkg::*;
(
  input  logic [NUM_CELLS-1:0] occupied,
  input  logic [3:0]           addr,
  output logic                 cell_legal,
  output logic [3:0]           first_empty
);

  always_comb begin
    cell_legal  = 1'b0;
    first_empty = BAD_ADDR;
    for (int unsigned i = 0; i < NUM_CELLS; i++) begin
      if (addr == 4'(i)) cell_legal = ~occupied[i];
    end
    // Scan downwards so the lowest empty index is the last one written.
    for (int unsigned i = NUM_CELLS; i > 0; i--) begin
      if (!occupied[i-1]) first_empty = 4'(i - 1);
    end
  end

endmodule

// File: rtl/game_turn_ctrl.sv
// Turn sequencer: arbitrates the board write port between human and AI, validates moves, ends the game.
// Optional AI_WATCHDOG_EN: timeout / illegal-AI fallback to the lowest empty cell.
module game_turn_ctrl
  import tictac_pkg::*;
#(
  parameter int unsigned AI_TIMEOUT = 16
) (
  input  logic        ph1,
  input  logic        reset,
  input  logic        start,
  input  logic        p1_first,
  input  logic        move_valid,
  input  logic [3:0]  move_addr,
  output logic        move_reject,
  output logic        ai_req,
  input  logic        ai_ack,
  input  logic [3:0]  ai_addr,
  input  logic [17:0] gBoard,
  input  logic [1:0]  win_status,
  output logic        mem_we,
  output logic [3:0]  mem_addr,
  output logic [1:0]  mem_data,
  output logic [1:0]  turn,
  output logic [3:0]  move_count,
  output logic        game_over,
  output logic [1:0]  result,
  output logic        ai_error
);

  turn_state state_q, state_d;
  logic [3:0] addr_q, addr_d;
  logic [3:0] count_q, count_d;
  logic [1:0] result_q, result_d;
  logic       ai_err_q, ai_err_d;
  logic       reject_q, reject_d;

  logic [NUM_CELLS-1:0] occupied;
  logic                 unused_low;
  logic [3:0]           chk_addr;
  logic                 legal;
  logic [3:0]           first_empty;

  always_comb begin
    occupied   = '0;
    unused_low = 1'b0;
    for (int unsigned i = 0; i < NUM_CELLS; i++) begin
      occupied[i] = gBoard[2*i+1];
      unused_low  = unused_low ^ gBoard[2*i];
    end
  end

  // One decoder serves both players: only one of them can be moving at a time.
  assign chk_addr = (state_q == P2_REQ) ? ai_addr : move_addr;

  cell_decode u_dec (
    .occupied    (occupied),
    .addr        (chk_addr),
    .cell_legal  (legal),
    .first_empty (first_empty)
  );

`ifdef AI_WATCHDOG_EN
  logic [4:0] wd_q, wd_d;
  logic       wd_expired;

  assign wd_expired = (wd_q == 5'(AI_TIMEOUT - 1));

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) wd_q <= '0;
    else       wd_q <= wd_d;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^AI_TIMEOUT;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    count_d  = count_q;
    result_d = result_q;
    ai_err_d = ai_err_q;
    reject_d = 1'b0;
`ifdef AI_WATCHDOG_EN
    wd_d     = '0;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          count_d  = '0;
          result_d = NOWIN;
          ai_err_d = 1'b0;
          state_d  = p1_first ? P1_WAIT : P2_REQ;
        end
      end
      P1_WAIT: begin
        if (move_valid) begin
          if (legal) begin
            addr_d  = move_addr;
            state_d = P1_WRITE;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      P1_WRITE: begin
        if (count_q < 4'(NUM_CELLS)) count_d = count_q + 4'd1;
        state_d = P1_CHECK;
      end
      P1_CHECK: begin
        if (win_status == P1WIN) begin
          result_d = P1WIN;
          state_d  = DONE;
        end else if (count_q == 4'(NUM_CELLS) || win_status == TIE) begin
          result_d = TIE;
          state_d  = DONE;
        end else begin
          state_d = P2_REQ;
        end
      end
      P2_REQ: begin
`ifdef AI_WATCHDOG_EN
        wd_d = wd_q + 5'd1;
        if ((ai_ack && !legal) || (!ai_ack && wd_expired)) begin
          ai_err_d = ai_err_q | ai_ack;
          if (first_empty != BAD_ADDR) begin
            addr_d  = first_empty;
            state_d = P2_WRITE;
          end else begin
            result_d = NOWIN;
            state_d  = DONE;
          end
        end else if (ai_ack) begin
          addr_d  = ai_addr;
          state_d = P2_WRITE;
        end
`else
        if (ai_ack) begin
          if (legal) begin
            addr_d  = ai_addr;
            state_d = P2_WRITE;
          end else begin
            ai_err_d = 1'b1;
            result_d = NOWIN;
            state_d  = DONE;
          end
        end
`endif
      end
      P2_WRITE: begin
        if (count_q < 4'(NUM_CELLS)) count_d = count_q + 4'd1;
        state_d = P2_CHECK;
      end
      P2_CHECK: begin
        if (win_status == P2WIN) begin
          result_d = P2WIN;
          state_d  = DONE;
        end else if (count_q == 4'(NUM_CELLS) || win_status == TIE) begin
          result_d = TIE;
          state_d  = DONE;
        end else begin
          state_d = P1_WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      count_q  <= '0;
      result_q <= NOWIN;
      ai_err_q <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      result_q <= result_d;
      ai_err_q <= ai_err_d;
      reject_q <= reject_d;
    end
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = BAD_ADDR;
    mem_data = EMPTY;
    turn     = 2'b00;
    case (state_q)
      P1_WAIT, P1_CHECK: turn = P1;
      P1_WRITE: begin
        turn     = P1;
        mem_we   = 1'b1;
        mem_addr = addr_q;
        mem_data = P1;
      end
      P2_REQ, P2_CHECK: turn = P2;
      P2_WRITE: begin
        turn     = P2;
        mem_we   = 1'b1;
        mem_addr = addr_q;
        mem_data = P2;
      end
      default: turn = 2'b00;
    endcase
  end

  assign ai_req      = (state_q == P2_REQ);
  assign game_over   = (state_q == DONE);
  assign move_reject = reject_q;
  assign move_count  = count_q;
  assign result      = result_q;
  assign ai_error    = ai_err_q;

endmodule
